i2c_target_model: RTL and testbench

- Synthesizable I2C target (slave) that sits directly downstream of the I2C-APB master on the shared sda/scl bus.
- Decodes START/STOP, matches a 7-bit address and ACKs.
- Supports register-pointer writes, auto-incrementing data writes and reads.
- Gives the bench and assertions a deterministic, cycle-accurate far end to exercise master transactions against.

---
 rtl/i2c_pkg.sv | 27 ++
 rtl/i2c_line_sync.sv | 65 ++++++
 rtl/i2c_target_model.sv | 176 +++++++++++++++++
 tb/tb_i2c_target_model.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C target model: FSM state encoding, the
// acknowledge bit levels and the R/W bit encodings of the address byte.
// -----------------------------------------------------------------------------
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RDATA_ACK,
      IGNORE
   } i2c_tgt_state_t;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

   localparam logic READ  = 1'b1;
   localparam logic WRITE = 1'b0;

endpackage

// File: rtl/i2c_line_sync.sv
// -----------------------------------------------------------------------------
// i2c_line_sync
// Brings scl/sda into the core_clk domain (2-FF synchronizer + 1-FF history)
// and produces single-cycle bus event pulses.
//
// Ports:
//   core_clk    in   core clock
//   PRESETn     in   synchronous active-low reset
//   scl_i       in   raw scl line level
//   sda_i       in   raw sda line level
//   sda_lvl     out  synchronized sda level, aligned with the event pulses
//   start_p     out  START (sda falls while scl high)
//   stop_p      out  STOP  (sda rises while scl high)
//   scl_rise_p  out  scl rising edge (sample point)
//   scl_fall_p  out  scl falling edge (drive-change point)
// -----------------------------------------------------------------------------
module i2c_line_sync (
   input  logic core_clk,
   input  logic PRESETn,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_lvl,
   output logic start_p,
   output logic stop_p,
   output logic scl_rise_p,
   output logic scl_fall_p
);

   logic scl_p0, scl_p1, scl_p2;
   logic sda_p0, sda_p1, sda_p2;

   // The history stage holds the previous synchronized level, so sda_p2 is
   // the level that was stable just before any edge reported this cycle.
   assign sda_lvl = sda_p2;

   always_ff @(posedge core_clk) begin
      if (!PRESETn) begin
         // Idle bus is high; resetting to 1 avoids a false edge on release.
         scl_p0     <= 1'b1;
         scl_p1     <= 1'b1;
         scl_p2     <= 1'b1;
         sda_p0     <= 1'b1;
         sda_p1     <= 1'b1;
         sda_p2     <= 1'b1;
         start_p    <= 1'b0;
         stop_p     <= 1'b0;
         scl_rise_p <= 1'b0;
         scl_fall_p <= 1'b0;
      end else begin
         // stage p0/p1: metastability synchronizer
         scl_p0     <= scl_i;
         scl_p1     <= scl_p0;
         sda_p0     <= sda_i;
         sda_p1     <= sda_p0;
         // stage p2: history, events registered so they land 3 cycles after the pin
         scl_p2     <= scl_p1;
         sda_p2     <= sda_p1;
         start_p    <= scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
         stop_p     <= scl_p1 & scl_p2 & ~sda_p2 & sda_p1;
         scl_rise_p <= scl_p1 & ~scl_p2;
         scl_fall_p <= ~scl_p1 & scl_p2;
      end
   end

endmodule

// File: rtl/i2c_target_model.sv
// -----------------------------------------------------------------------------
// i2c_target_model
// I2C target with a DEPTH x 8 register file. A write transfer sets the
// register pointer from its first data byte and then writes subsequent bytes
// with auto-increment; a read transfer returns regs[ptr] with auto-increment
// on every master ACK.
//
// Ports:
//   core_clk   in   sole clock (>= 8x scl)
//   PRESETn    in   synchronous active-low reset
//   scl_i      in   resolved scl level
//   sda_i      in   resolved sda level
//   sda_oe     out  1 = pull sda low
//   busy       out  address matched, until STOP / repeated START
//   wr_strobe  out  one-cycle pulse per committed data byte
//   wr_addr    out  register index of committed byte
//   wr_data    out  committed byte
//   peek_addr  in   backdoor read index
//   peek_data  out  regs[peek_addr] (combinational)
// -----------------------------------------------------------------------------
module i2c_target_model
   import i2c_pkg::*;
#(
   parameter logic [6:0] TARGET_ADDR = 7'h50,
   parameter int         DEPTH       = 16,
   parameter int         PTR_W       = 4
) (
   input  logic             core_clk,
   input  logic             PRESETn,
   input  logic             scl_i,
   input  logic             sda_i,
   output logic             sda_oe,
   output logic             busy,
   output logic             wr_strobe,
   output logic [PTR_W-1:0] wr_addr,
   output logic [7:0]       wr_data,
   input  logic [PTR_W-1:0] peek_addr,
   output logic [7:0]       peek_data
);

   logic sda_lvl, start_p, stop_p, scl_rise_p, scl_fall_p;

   i2c_line_sync u_sync (
      .core_clk   (core_clk),
      .PRESETn    (PRESETn),
      .scl_i      (scl_i),
      .sda_i      (sda_i),
      .sda_lvl    (sda_lvl),
      .start_p    (start_p),
      .stop_p     (stop_p),
      .scl_rise_p (scl_rise_p),
      .scl_fall_p (scl_fall_p)
   );

   i2c_tgt_state_t   state, state_nxt;
   logic [2:0]       bit_cnt;
   logic [7:0]       shift, tx_byte, byte_in;
   logic [PTR_W-1:0] ptr;
   logic [7:0]       regs [DEPTH];
   logic             rw, ack_phase, bus_evt, byte_state;
   logic             sda_oe_d, busy_d, commit, ptr_inc, ptr_load;

   assign byte_in    = {shift[6:0], sda_lvl};
   assign bus_evt    = start_p | stop_p;
   assign byte_state = (state == ADDR) || (state == PTR) ||
                       (state == WDATA) || (state == RDATA);
   assign peek_data  = regs[peek_addr];

   // ack_phase: in target-driven ACK states it marks "ACK already driven";
   // in RDATA_ACK it marks "master ACKed, next byte starts on scl_fall".
   always_ff @(posedge core_clk) begin
      if (!PRESETn) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (start_p)     state_nxt = ADDR;
      else if (stop_p) state_nxt = IDLE;
      else begin
         case (state)
            ADDR:      if (scl_rise_p && bit_cnt == 3'd7)
                          state_nxt = (byte_in[7:1] == TARGET_ADDR) ? ADDR_ACK : IGNORE;
            ADDR_ACK:  if (scl_fall_p && ack_phase)
                          state_nxt = (rw == WRITE) ? PTR : RDATA;
            PTR:       if (scl_rise_p && bit_cnt == 3'd7) state_nxt = PTR_ACK;
            PTR_ACK:   if (scl_fall_p && ack_phase) state_nxt = WDATA;
            WDATA:     if (scl_rise_p && bit_cnt == 3'd7) state_nxt = WDATA_ACK;
            WDATA_ACK: if (scl_fall_p && ack_phase) state_nxt = WDATA;
            // bit_cnt wraps to 0 after the 8th rise; the first fall in RDATA
            // always follows at least one rise, so 0 here means byte done.
            RDATA:     if (scl_fall_p && bit_cnt == 3'd0) state_nxt = RDATA_ACK;
            RDATA_ACK: begin
               if (scl_rise_p && sda_lvl == I2C_NACK) state_nxt = IGNORE;
               else if (scl_fall_p && ack_phase)      state_nxt = RDATA;
            end
            default:   state_nxt = state;
         endcase
      end
   end

   always_comb begin
      sda_oe_d = sda_oe;
      busy_d   = busy;
      commit   = 1'b0;
      ptr_inc  = 1'b0;
      ptr_load = 1'b0;
      if (bus_evt) begin
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else begin
         case (state)
            ADDR:      if (scl_rise_p && bit_cnt == 3'd7 && byte_in[7:1] == TARGET_ADDR)
                          busy_d = 1'b1;
            ADDR_ACK:  if (scl_fall_p) begin
                          if (!ack_phase)       sda_oe_d = 1'b1;
                          else if (rw == READ)  sda_oe_d = ~regs[ptr][7];
                          else                  sda_oe_d = 1'b0;
                       end
            PTR:       if (scl_rise_p && bit_cnt == 3'd7) ptr_load = 1'b1;
            PTR_ACK:   if (scl_fall_p) sda_oe_d = ~ack_phase;
            WDATA_ACK: if (scl_fall_p) begin
                          sda_oe_d = ~ack_phase;
                          commit   = ~ack_phase;
                          ptr_inc  = ~ack_phase;
                       end
            RDATA:     if (scl_fall_p)
                          sda_oe_d = (bit_cnt == 3'd0) ? 1'b0 : ~tx_byte[3'd7 - bit_cnt];
            RDATA_ACK: begin
               if (scl_rise_p && sda_lvl == I2C_ACK) ptr_inc = 1'b1;
               if (scl_fall_p && ack_phase)          sda_oe_d = ~regs[ptr][7];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge core_clk) begin
      if (!PRESETn) begin
         sda_oe    <= 1'b0;
         busy      <= 1'b0;
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         ptr       <= '0;
         bit_cnt   <= '0;
         ack_phase <= 1'b0;
         rw        <= WRITE;
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else begin
         sda_oe    <= sda_oe_d;
         busy      <= busy_d;
         wr_strobe <= commit;
         if (commit) begin
            regs[ptr] <= shift;
            wr_addr   <= ptr;
            wr_data   <= shift;
         end
         if (ptr_load)     ptr <= byte_in[PTR_W-1:0];
         else if (ptr_inc) ptr <= ptr + 1'b1;
         if (state == ADDR && state_nxt == ADDR_ACK) rw <= sda_lvl;
         if (bus_evt || state != state_nxt)          bit_cnt <= '0;
         else if (scl_rise_p && byte_state)          bit_cnt <= bit_cnt + 1'b1;
         if (bus_evt || state != state_nxt)          ack_phase <= 1'b0;
         else if (scl_fall_p && (state == ADDR_ACK || state == PTR_ACK || state == WDATA_ACK))
            ack_phase <= 1'b1;
         else if (scl_rise_p && state == RDATA_ACK)  ack_phase <= 1'b1;
      end
   end

   always_ff @(posedge core_clk) begin
      if (!bus_evt && scl_rise_p && byte_state) shift <= byte_in;
      if (state_nxt == RDATA && state != RDATA) tx_byte <= regs[ptr];
   end

endmodule

// File: tb/tb_i2c_target_model.sv
// -----------------------------------------------------------------------------
// tb_i2c_target_model
// Bit-banged I2C master driving the target, with a transaction-level model of
// the register file and pointer used to predict ACKs, read data and commits.
// -----------------------------------------------------------------------------
module tb_i2c_target_model;

   localparam int Q = 5;

   logic       core_clk = 1'b0;
   logic       PRESETn  = 1'b0;
   logic       scl_m    = 1'b1;
   logic       sda_m    = 1'b1;
   logic [3:0] peek_addr = '0;
   logic       scl_i, sda_i, sda_oe, busy, wr_strobe;
   logic [3:0] wr_addr;
   logic [7:0] wr_data, peek_data;

   assign scl_i = scl_m;
   assign sda_i = sda_m & ~sda_oe;

   always #5 core_clk = ~core_clk;

   i2c_target_model dut (
      .core_clk  (core_clk),
      .PRESETn   (PRESETn),
      .scl_i     (scl_i),
      .sda_i     (sda_i),
      .sda_oe    (sda_oe),
      .busy      (busy),
      .wr_strobe (wr_strobe),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .peek_addr (peek_addr),
      .peek_data (peek_data)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  ref_regs [16];
   int          ref_ptr;
   logic [11:0] wq [$];
   bit          oe_seen;

   always @(negedge core_clk) begin
      if (wr_strobe) wq.push_back({wr_addr, wr_data});
      if (sda_oe) oe_seen = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic qwait(input int n);
      repeat (n) @(negedge core_clk);
   endtask

   task automatic bit_xfer(input logic b, output logic s);
      sda_m = b;    qwait(Q);
      scl_m = 1'b1; qwait(Q);
      s = sda_i;    qwait(Q);
      scl_m = 1'b0; qwait(Q);
   endtask

   task automatic i2c_start;
      sda_m = 1'b1; qwait(Q);
      scl_m = 1'b1; qwait(Q);
      sda_m = 1'b0; qwait(Q);
      scl_m = 1'b0; qwait(Q);
   endtask

   task automatic i2c_stop;
      sda_m = 1'b0; qwait(Q);
      scl_m = 1'b1; qwait(Q);
      sda_m = 1'b1; qwait(2 * Q);
   endtask

   task automatic wr_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
      bit_xfer(1'b1, s);
      ack = ~s;
   endtask

   task automatic rd_byte(input logic m_ack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, s);
         d[i] = s;
      end
      bit_xfer(~m_ack, s);
   endtask

   task automatic check_peek(input string tag);
      for (int i = 0; i < 16; i++) begin
         peek_addr = i[3:0];
         #1;
         check($sformatf("%s_peek%0d", tag, i), peek_data, ref_regs[i]);
      end
   endtask

   task automatic do_write(input logic [7:0] pb, input logic [7:0] dq [$], input string tag);
      logic        ack;
      int          p;
      logic [11:0] exp_q [$];
      wq.delete();
      i2c_start;
      wr_byte(8'hA0, ack); check($sformatf("%s_addr_ack", tag), ack, 1'b1);
      check($sformatf("%s_busy", tag), busy, 1'b1);
      wr_byte(pb, ack);    check($sformatf("%s_ptr_ack", tag), ack, 1'b1);
      p = pb[3:0];
      foreach (dq[i]) begin
         wr_byte(dq[i], ack);
         check($sformatf("%s_data_ack%0d", tag, i), ack, 1'b1);
         ref_regs[p] = dq[i];
         exp_q.push_back({p[3:0], dq[i]});
         p = (p + 1) % 16;
      end
      i2c_stop;
      check($sformatf("%s_busy_stop", tag), busy, 1'b0);
      check($sformatf("%s_nstrobe", tag), wq.size(), exp_q.size());
      foreach (exp_q[i])
         check($sformatf("%s_strobe%0d", tag, i), (i < wq.size()) ? wq[i] : 12'hfff, exp_q[i]);
   endtask

   task automatic do_read(input logic [7:0] pb, input int n, input string tag);
      logic       ack;
      logic [7:0] d;
      wq.delete();
      i2c_start;
      wr_byte(8'hA0, ack); check($sformatf("%s_waddr_ack", tag), ack, 1'b1);
      wr_byte(pb, ack);    check($sformatf("%s_ptr_ack", tag), ack, 1'b1);
      ref_ptr = pb[3:0];
      i2c_start;
      wr_byte(8'hA1, ack); check($sformatf("%s_raddr_ack", tag), ack, 1'b1);
      for (int i = 0; i < n; i++) begin
         rd_byte(i != n - 1, d);
         check($sformatf("%s_rdata%0d", tag, i), d, ref_regs[ref_ptr]);
         if (i != n - 1) ref_ptr = (ref_ptr + 1) % 16;
      end
      check($sformatf("%s_nack_release", tag), sda_oe, 1'b0);
      check($sformatf("%s_busy_ignore", tag), busy, 1'b1);
      i2c_stop;
      check($sformatf("%s_busy_stop", tag), busy, 1'b0);
      check($sformatf("%s_no_strobe", tag), wq.size(), 0);
   endtask

   initial begin
      logic       ack, s;
      logic [7:0] dq [$];
      logic [7:0] pb;
      int         n;

      foreach (ref_regs[i]) ref_regs[i] = 8'h00;

      // reset
      qwait(4);
      check("rst_sda_oe", sda_oe, 1'b0);
      check("rst_busy", busy, 1'b0);
      check_peek("rst");
      PRESETn = 1'b1;
      qwait(4);

      // write burst then read back with repeated START
      dq = {8'h11, 8'h22};
      do_write(8'h03, dq, "burst");
      check_peek("burst");
      do_read(8'h03, 2, "rdback");

      // address mismatch: never driven, never busy
      oe_seen = 1'b0;
      i2c_start;
      wr_byte(8'hA2, ack); check("nomatch_ack", ack, 1'b0);
      check("nomatch_busy", busy, 1'b0);
      wr_byte(8'h5A, ack); check("nomatch_data_ack", ack, 1'b0);
      i2c_stop;
      check("nomatch_oe_seen", oe_seen, 1'b0);
      check("nomatch_busy_stop", busy, 1'b0);

      // pointer wrap
      dq = {8'hAA, 8'hBB};
      do_write(8'h0F, dq, "wrap");
      check_peek("wrap");
      do_read(8'h0F, 3, "wrap_rd");

      // randomized bursts (pointer upper bits random too)
      for (int t = 0; t < 4; t++) begin
         pb = 8'($urandom_range(0, 255));
         n  = $urandom_range(1, 4);
         dq.delete();
         for (int i = 0; i < n; i++) dq.push_back(8'($urandom));
         do_write(pb, dq, $sformatf("rnd%0d_wr", t));
         do_read(8'($urandom_range(0, 255)), $urandom_range(1, 4), $sformatf("rnd%0d_rd", t));
      end
      check_peek("rnd");

      // abort: STOP after 5 data bits
      wq.delete();
      i2c_start;
      wr_byte(8'hA0, ack); check("abort_addr_ack", ack, 1'b1);
      wr_byte(8'h05, ack); check("abort_ptr_ack", ack, 1'b1);
      for (int i = 0; i < 5; i++) bit_xfer(~ref_regs[5][7 - i], s);
      i2c_stop;
      check("abort_no_strobe", wq.size(), 0);
      check("abort_busy", busy, 1'b0);
      check("abort_sda_oe", sda_oe, 1'b0);
      check_peek("abort");

      // reset in the middle of a read while the target pulls sda low
      dq = {8'h00};
      do_write(8'h07, dq, "pre_rst");
      i2c_start;
      wr_byte(8'hA0, ack);
      wr_byte(8'h07, ack);
      i2c_start;
      wr_byte(8'hA1, ack); check("midrd_addr_ack", ack, 1'b1);
      check("midrd_drive", sda_oe, 1'b1);
      bit_xfer(1'b1, s);   check("midrd_bit7", s, 1'b0);
      PRESETn = 1'b0;
      @(posedge core_clk); #1;
      check("midrd_rst_release", sda_oe, 1'b0);
      check("midrd_rst_busy", busy, 1'b0);
      qwait(3);
      PRESETn = 1'b1;
      foreach (ref_regs[i]) ref_regs[i] = 8'h00;
      i2c_stop;
      check_peek("post_rst");
      do_read(8'h03, 1, "post_rst_rd");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
